// File: rtl/pow_pkg.sv
// Shared types and default widths for the sequential power unit.
package pow_pkg;

  localparam int POW_WIDTH     = 32;
  localparam int POW_EXP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pow_state_t;

endpackage

// File: rtl/pow_step.sv
// One MSB-first square-and-multiply step: square the accumulator, optionally
// multiply by the base, and flag any bits lost above WIDTH.
module pow_step
  import pow_pkg::*;
#(
  parameter int WIDTH = POW_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] base,
  input  logic             exp_bit,
  output logic [WIDTH-1:0] next_acc,
  output logic             step_ovf
);

  logic [2*WIDTH-1:0] sq_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] t_s;

  // Square, conditional multiply by base on the truncated square, overflow detect
  always_comb begin
    sq_s   = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, acc};
    prod_s = {{WIDTH{1'b0}}, sq_s[WIDTH-1:0]} * {{WIDTH{1'b0}}, base};
    if (exp_bit) begin
      t_s = prod_s;
    end else begin
      t_s = sq_s;
    end
    next_acc = t_s[WIDTH-1:0];
    step_ovf = (|sq_s[2*WIDTH-1:WIDTH]) | (|t_s[2*WIDTH-1:WIDTH]);
  end

endmodule

// File: rtl/pow_seq.sv
// Sequential base**exp (mod 2^WIDTH) unit, one exponent bit per cycle,
// with valid/ready handshakes and a sticky exact overflow flag.
module pow_seq
  import pow_pkg::*;
#(
  parameter int WIDTH     = POW_WIDTH,
  parameter int EXP_WIDTH = POW_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_base,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_ovf
);

  localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  pow_state_t           state_r;
  pow_state_t           state_nxt_s;
  logic [WIDTH-1:0]     base_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [WIDTH-1:0]     acc_r;
  logic                 ovf_r;
  logic [CW-1:0]        bitcnt_r;
  logic [WIDTH-1:0]     next_acc_s;
  logic                 step_ovf_s;

  pow_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .base     (base_r),
    .exp_bit  (exp_r[bitcnt_r]),
    .next_acc (next_acc_s),
    .step_ovf (step_ovf_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (bitcnt_r == {CW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand capture and iteration datapath; acc/ovf hold steady in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r   <= {WIDTH{1'b0}};
      exp_r    <= {EXP_WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      ovf_r    <= 1'b0;
      bitcnt_r <= {CW{1'b0}};
    end else if ((state_r == IDLE) && in_valid) begin
      base_r   <= in_base;
      exp_r    <= in_exp;
      acc_r    <= {{(WIDTH-1){1'b0}}, 1'b1};
      ovf_r    <= 1'b0;
      bitcnt_r <= CW'(EXP_WIDTH - 1);
    end else if (state_r == BUSY) begin
      acc_r <= next_acc_s;
      ovf_r <= ovf_r | step_ovf_s;
      if (bitcnt_r != {CW{1'b0}}) begin
        bitcnt_r <= bitcnt_r - CW'(1'b1);
      end else begin
        bitcnt_r <= bitcnt_r;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign out_result = acc_r;
  assign out_ovf    = ovf_r;

endmodule

// File: tb/tb_pow_seq.sv
// Randomised self-checking bench for pow_seq against an arithmetic model.
module tb_pow_seq;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = 32'd0;
  logic [31:0] in_exp = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          acc_cyc;
  } exp_t;
  exp_t q[$];

  pow_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_base    (in_base),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: LSB-first modular exponentiation plus exact overflow by
  // repeated multiplication (any base >= 2 exceeds 2^32 within 33 products).
  function automatic void model(input logic [31:0] b, input logic [31:0] e,
                                output logic [31:0] r, output logic o);
    longint unsigned acc = 64'd1;
    longint unsigned sq  = {32'd0, b};
    longint unsigned p   = 64'd1;
    logic [31:0] k = e;
    for (int i = 0; i < 32; i++) begin
      if (k[0]) acc = (acc * sq) & 64'hFFFF_FFFF;
      sq = (sq * sq) & 64'hFFFF_FFFF;
      k = k >> 1;
    end
    r = acc[31:0];
    o = 1'b0;
    for (longint i = 0; i < longint'({32'd0, e}) && i < 33; i++) begin
      p = p * {32'd0, b};
      if (p >= 64'h1_0000_0000) begin
        o = 1'b1;
        break;
      end
    end
  endfunction

  task automatic pin(input logic [31:0] b, input logic [31:0] e,
                     input logic [31:0] want_r, input logic want_o);
    logic [31:0] r;
    logic o;
    model(b, e, r, o);
    check("model_result", r, want_r);
    check("model_ovf", o, want_o);
  endtask

  // Compare process: every DONE cycle must show the oldest expected result
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      check("ready_valid_excl", in_ready & out_valid, 1'b0);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("out_result", out_result, q[0].res);
          check("out_ovf", out_ovf, q[0].ovf);
          if (!prev_valid) check("latency", cyc - q[0].acc_cyc, LAT);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] b, input logic [31:0] e);
    exp_t x;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
      return;
    end
    in_valid = 1'b1;
    in_base  = b;
    in_exp   = e;
    model(b, e, x.res, x.ovf);
    x.acc_cyc = cyc + 1;
    q.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_base  = $urandom;
    in_exp   = $urandom;
  endtask

  task automatic wait_result(input int stall);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("result_timeout", out_valid, 1'b1);
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready, 1'b1);
    check("out_valid_after_hs", out_valid, 1'b0);
  endtask

  task automatic op(input logic [31:0] b, input logic [31:0] e, input int stall);
    send(b, e);
    wait_result(stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pin(32'd3, 32'd5, 32'd243, 1'b0);
    pin(32'd2, 32'd32, 32'd0, 1'b1);
    pin(32'd2, 32'd31, 32'h8000_0000, 1'b0);
    pin(32'd0, 32'd0, 32'd1, 1'b0);
    pin(32'd0, 32'd7, 32'd0, 1'b0);
    pin(32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    pin(32'h0000_FFFF, 32'd2, 32'hFFFE_0001, 1'b0);
    pin(32'h0001_0000, 32'd2, 32'd0, 1'b1);

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_ovf", out_ovf, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Counter-style stream: 2^0 .. 2^31
    for (int k = 0; k < 32; k++) begin
      logic [31:0] want;
      want = 32'd1 << k;
      pin(32'd2, k, want, 1'b0);
      op(32'd2, k, 0);
    end

    op(32'd2, 32'd32, 0);
    op(32'd2, 32'd31, 0);
    op(32'd3, 32'd5, 0);
    op(32'd0, 32'd0, 0);
    op(32'd0, 32'd7, 0);
    op(32'd1, 32'hFFFF_FFFF, 0);
    op(32'h0000_FFFF, 32'd2, 0);
    op(32'h0001_0000, 32'd2, 0);

    // Long stall in DONE with an ignored in_valid pulse
    send(32'd7, 32'd11);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      in_valid = (i == 4);
      in_base  = 32'd9;
      in_exp   = 32'd9;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release_ready", in_ready, 1'b1);
    check("stall_release_valid", out_valid, 1'b0);

    // Randomised operands, mixing small bases/exponents with full-range ones
    for (int i = 0; i < 24; i++) begin
      logic [31:0] b;
      logic [31:0] e;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 6)) : $urandom;
      e = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      out_ready = $urandom_range(0, 1);
      op(b, e, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of BUSY
    send(32'd3, 32'd20);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_out_ovf", out_ovf, 1'b0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pin(32'd5, 32'd3, 32'd125, 1'b0);
    op(32'd5, 32'd3, 0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
